// File: rtl/fe_decode_queue.sv
// fe_decode_queue: circular FIFO of decoded instructions between the decoder
// and rename. It presents the oldest entry until rename takes it, and a
// back-end mispredict empties it so no wrong-path instruction reaches rename.
// Optional feature macro: FE_QUEUE_BYPASS_EN. When it is defined, an empty
// queue forwards dec_instr_i straight to decoded_o with zero latency.
package fe_decode_queue_pkg;
    localparam int DECODED_INSTRUCTION_WIDTH = 32;
endpackage

module fe_decode_queue
    import fe_decode_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DECODED_INSTRUCTION_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [WIDTH-1:0]       dec_instr_i,
    input  logic                   dec_v_i,
    output logic                   dec_ready_o,
    output logic [WIDTH-1:0]       decoded_o,
    output logic                   decoded_v_o,
    input  logic                   rename_decode_ready_i,
    input  logic                   be_fe_mispredict_i,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] STEP_C  = PW'(1);

    logic [WIDTH-1:0] storage_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [PW-1:0]    head_nxt_s;
    logic [PW-1:0]    tail_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_s;
    logic             empty_s;
    logic             enq_s;
    logic             deq_s;
    logic             bypass_take_s;

    // Occupancy comes only from the registered count, so dec_ready_o never
    // depends on rename in the same cycle.
    assign full_s      = (count_r == DEPTH_C);
    assign empty_s     = (count_r == {CW{1'b0}});
    assign dec_ready_o = !full_s;
    assign count_o     = count_r;

`ifdef FE_QUEUE_BYPASS_EN
    // Output select: an empty, non-flushing queue shows the decoder input directly.
    always_comb begin
        decoded_o     = storage_r[head_r];
        decoded_v_o   = !empty_s && !be_fe_mispredict_i;
        bypass_take_s = 1'b0;
        if (empty_s && !be_fe_mispredict_i) begin
            decoded_o     = dec_instr_i;
            decoded_v_o   = dec_v_i;
            bypass_take_s = dec_v_i && rename_decode_ready_i;
        end else begin
            bypass_take_s = 1'b0;
        end
    end
`else
    // Output select: always the oldest stored entry, gated off during a flush.
    always_comb begin
        decoded_o     = storage_r[head_r];
        decoded_v_o   = !empty_s && !be_fe_mispredict_i;
        bypass_take_s = 1'b0;
    end
`endif

    // A bypassed instruction is consumed by rename and never written.
    assign enq_s = dec_v_i && !full_s && !be_fe_mispredict_i && !bypass_take_s;
    assign deq_s = !empty_s && rename_decode_ready_i && !be_fe_mispredict_i;

    // Next pointer/count values; a flush overrides every other event.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        if (be_fe_mispredict_i) begin
            head_nxt_s  = {PW{1'b0}};
            tail_nxt_s  = {PW{1'b0}};
            count_nxt_s = {CW{1'b0}};
        end else begin
            if (enq_s) begin
                tail_nxt_s = tail_r + STEP_C;
            end else begin
                tail_nxt_s = tail_r;
            end
            if (deq_s) begin
                head_nxt_s = head_r + STEP_C;
            end else begin
                head_nxt_s = head_r;
            end
            case ({enq_s, deq_s})
                2'b10:   count_nxt_s = count_r + ONE_C;
                2'b01:   count_nxt_s = count_r - ONE_C;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and count registers; reset discards all queued entries at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Storage write; contents are never cleared because validity lives in count.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            storage_r[tail_r] <= dec_instr_i;
        end
    end

endmodule

// File: tb/tb_fe_decode_queue.sv
// Self-checking bench for fe_decode_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fe_decode_queue;
    localparam int DEPTH = 8;
    localparam int W     = fe_decode_queue_pkg::DECODED_INSTRUCTION_WIDTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  dec_instr = '0;
    logic          dec_v = 1'b0;
    logic          dec_ready;
    logic [W-1:0]  decoded;
    logic          decoded_v;
    logic          rdy = 1'b0;
    logic          mp = 1'b0;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mq[$];

    fe_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(rst), .dec_instr_i(dec_instr), .dec_v_i(dec_v),
        .dec_ready_o(dec_ready), .decoded_o(decoded), .decoded_v_o(decoded_v),
        .rename_decode_ready_i(rdy), .be_fe_mispredict_i(mp), .count_o(count)
    );

    always #5 clk = ~clk;

    function automatic logic exp_valid();
        if (mp) return 1'b0;
        if (mq.size() > 0) return 1'b1;
`ifdef FE_QUEUE_BYPASS_EN
        return dec_v;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] exp_data();
        if (mq.size() > 0) return mq[0];
        return dec_instr;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic m);
        @(negedge clk);
        dec_v = v; dec_instr = d; rdy = r; mp = m;
        #1;
    endtask

    // Advance one clock edge and apply the same event to the reference queue.
    task automatic tick();
        logic acc, pop, byp;
        byp = 1'b0;
`ifdef FE_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && dec_v && rdy && !mp;
`endif
        acc = dec_v && (mq.size() < DEPTH) && !mp && !byp;
        pop = (mq.size() > 0) && rdy && !mp;
        @(posedge clk);
        if (mp) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(dec_instr);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; dec_v = 1'b0; rdy = 1'b0; mp = 1'b0; dec_instr = '0;
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", dec_ready); end
        checks++; if (decoded_v !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", decoded_v); end
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    endtask

    task automatic test_stream();
        logic [W-1:0] got[$];
        logic [W-1:0] want[3];
        int maxc = 0;
        want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(1'b1, want[c], 1'b1, 1'b0);
            else       drive(1'b0, '0, 1'b1, 1'b0);
            if (decoded_v === 1'b1) got.push_back(decoded);
            if (int'(count) > maxc) maxc = int'(count);
            tick();
        end
        checks++;
        if (got.size() != 3 || got[0] !== want[0] || got[1] !== want[1] || got[2] !== want[2]) begin
            failures++; $display("FAIL stream_order got_n=%0d exp=11,22,33", got.size());
        end
        checks++; if (maxc > 1) begin failures++; $display("FAIL stream_maxcount got=%0d exp<=1", maxc); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, W'(9), 1'b0, 1'b0);
        checks++; if (count !== CW'(8)) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
        checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", dec_ready); end
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (count !== CW'(8)) begin failures++; $display("FAIL ninth_rejected got=%0d exp=8", count); end
        checks++; if (decoded !== W'(1) || decoded_v !== 1'b1) begin failures++; $display("FAIL full_head got=%h v=%b exp=1", decoded, decoded_v); end
        checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL full_deq_ready got=%b exp=0", dec_ready); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL after_deq_ready got=%b exp=1", dec_ready); end
        checks++; if (count !== CW'(7)) begin failures++; $display("FAIL after_deq_count got=%0d exp=7", count); end
        checks++; if (decoded !== W'(2)) begin failures++; $display("FAIL after_deq_head got=%h exp=2", decoded); end
        tick();
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'(32'h31 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, W'(32'h99), 1'b0, 1'b1);
        checks++; if (decoded_v !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", decoded_v); end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== '0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (decoded_v !== 1'b0) begin failures++; $display("FAIL flush_after_valid got=%b exp=0", decoded_v); end
        tick();
        drive(1'b1, W'(32'h44), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++; if (decoded !== W'(32'h44) || decoded_v !== 1'b1 || count !== CW'(1)) begin
            failures++; $display("FAIL flush_next got=%h v=%b cnt=%0d exp=44 1 1", decoded, decoded_v, count);
        end
        tick();
    endtask

    // Random traffic; n items, stall pattern chosen by mode (0: every third cycle, 1: random).
    task automatic test_traffic(input int n, input int mode, input int mp_pct);
        logic [W-1:0] sent[$];
        logic [W-1:0] got[$];
        logic v, r, m, ev;
        logic [W-1:0] d;
        int idx = 0, bad = 0, maxc = 0, c = 0;
        apply_reset();
        while ((idx < n || mq.size() > 0) && c < 600) begin
            v = (idx < n) && ($urandom_range(0, 3) != 0 || mode == 0);
            r = (mode == 0) ? (c % 3 != 2) : ($urandom_range(0, 9) < 7);
            m = ($urandom_range(0, 99) < mp_pct);
            d = $urandom;
            drive(v, d, r, m);
            ev = exp_valid();
            checks++;
            if (decoded_v !== ev || (ev && decoded !== exp_data())) begin
                failures++; $display("FAIL traffic_out cyc=%0d got=%h v=%b exp=%h v=%b", c, decoded, decoded_v, exp_data(), ev);
            end
            checks++;
            if (count !== CW'(mq.size()) || dec_ready !== (mq.size() < DEPTH)) begin
                failures++; $display("FAIL traffic_state cyc=%0d cnt=%0d rdy=%b exp_cnt=%0d", c, count, dec_ready, mq.size());
            end
            if (int'(count) > maxc) maxc = int'(count);
            if (m) begin
                sent.delete(); got.delete();
            end else begin
                if (decoded_v === 1'b1 && r) got.push_back(decoded);
                if (v && mq.size() < DEPTH) begin sent.push_back(d); idx++; end
            end
            tick();
            c++;
        end
        checks++; if (c >= 600) begin failures++; $display("FAIL traffic_timeout cycles=%0d exp<600", c); end
        for (int i = 0; i < sent.size(); i++) begin
            if (i >= got.size() || got[i] !== sent[i]) bad++;
        end
        checks++;
        if (bad != 0 || got.size() != sent.size()) begin
            failures++; $display("FAIL traffic_order bad=%0d got_n=%0d exp_n=%0d", bad, got.size(), sent.size());
        end
        checks++; if (maxc > DEPTH) begin failures++; $display("FAIL traffic_maxcount got=%0d exp<=%0d", maxc, DEPTH); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(32'h70 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== CW'(3)) begin failures++; $display("FAIL pre_areset_count got=%0d exp=3", count); end
        rst = 1'b1;
        #1;
        checks++; if (count !== '0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
        checks++; if (decoded_v !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", decoded_v); end
        rst = 1'b0;
        mq.delete();
    endtask

`ifdef FE_QUEUE_BYPASS_EN
    task automatic test_bypass();
        apply_reset();
        drive(1'b1, W'(32'h55), 1'b1, 1'b0);
        checks++; if (decoded !== W'(32'h55) || decoded_v !== 1'b1) begin
            failures++; $display("FAIL bypass_out got=%h v=%b exp=55 1", decoded, decoded_v);
        end
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++; if (count !== '0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_flush();
        test_traffic(20, 0, 0);
        test_async_reset();
        test_traffic(150, 1, 4);
`ifdef FE_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
